// File: rtl/spi_flash_pkg.sv
// Shared FSM states, opcodes and bit counts for the SPI flash word reader.
// ST_DUMMY exists only when SPI_FLASH_FAST_READ_EN is defined.
package spi_flash_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
      ST_DUMMY,
`endif
      ST_DATA,
      ST_DONE,
      ST_GAP
   } state_t;

   localparam logic [7:0] OPC_READ      = 8'h03;
   localparam logic [7:0] OPC_FAST_READ = 8'h0B;

   localparam int CMD_BITS   = 8;
   localparam int ADDR_BITS  = 24;
   localparam int DUMMY_BITS = 8;
   localparam int DATA_BITS  = 32;

   // The first received byte lands in the low byte of the returned word.
   function automatic logic [31:0] byte_swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI mode-0 clock divider: flash_clk toggles every CLK_DIV cycles while enabled.
// The rise/fall strobes are high in the cycle whose closing edge moves the clock.
module spi_clk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clock,
   input  logic resetb,
   input  logic i_en,
   output logic o_sclk,
   output logic o_rise,
   output logic o_fall
);

   localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

   logic [7:0] r_cnt;
   logic       r_sclk;
   logic       w_tc;

   assign w_tc   = i_en && (r_cnt == 8'd0);
   assign o_rise = w_tc && !r_sclk;
   assign o_fall = w_tc && r_sclk;
   assign o_sclk = r_sclk;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_cnt  <= RELOAD;
         r_sclk <= 1'b0;
      end else if (!i_en) begin
         r_cnt  <= RELOAD;
         r_sclk <= 1'b0;
      end else if (w_tc) begin
         r_cnt  <= RELOAD;
         r_sclk <= ~r_sclk;
      end else begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

endmodule

// File: rtl/spi_flash_reader.sv
// Reads one 32-bit little-endian word from SPI flash per request (READ 0x03).
// Define SPI_FLASH_FAST_READ_EN for FAST READ 0x0B with 8 dummy clocks.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | csb high, req_ready high, waiting for a request
// ST_CMD   | shifting the 8-bit opcode out on io0, MSB first
// ST_ADDR  | shifting the 24-bit address out on io0, MSB first
// ST_DUMMY | 8 dummy clocks with io0 low (fast read builds only)
// ST_DATA  | sampling 32 bits from io1 on flash_clk rising edges
// ST_DONE  | rsp_valid pulse, csb released
// ST_GAP   | csb held high for CSB_GAP cycles before the next request
module spi_flash_reader
   import spi_flash_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int CSB_GAP = 4
) (
   input  logic        clock,
   input  logic        resetb,
   input  logic        req_valid,
   input  logic [23:0] req_addr,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        flash_csb,
   output logic        flash_clk,
   output logic        flash_io0,
   input  logic        flash_io1
);

`ifdef SPI_FLASH_FAST_READ_EN
   localparam logic [7:0] OPCODE = OPC_FAST_READ;
   logic [2:0]  r_dummy_cnt;
`else
   localparam logic [7:0] OPCODE = OPC_READ;
`endif

   state_t      r_state;
   logic        r_ready;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_data;
   logic        r_csb;
   logic        r_io0;
   logic [30:0] r_tx;
   logic [31:0] r_rx;
   logic [4:0]  r_bit_cnt;
   logic [7:0]  r_gap_cnt;
   logic        w_clk_en;
   logic        w_rise;
   logic        w_fall;

   assign w_clk_en  = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_GAP);
   assign req_ready = r_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign flash_csb = r_csb;
   assign flash_io0 = r_io0;

   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clock  (clock),
      .resetb (resetb),
      .i_en   (w_clk_en),
      .o_sclk (flash_clk),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_state     <= ST_IDLE;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_csb       <= 1'b1;
         r_io0       <= 1'b0;
         r_tx        <= '0;
         r_rx        <= '0;
         r_bit_cnt   <= '0;
         r_gap_cnt   <= '0;
`ifdef SPI_FLASH_FAST_READ_EN
         r_dummy_cnt <= '0;
`endif
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid && r_ready) begin
                  r_ready   <= 1'b0;
                  r_csb     <= 1'b0;
                  r_io0     <= OPCODE[7];
                  r_tx      <= {OPCODE[6:0], req_addr};
                  r_bit_cnt <= 5'(CMD_BITS - 1);
                  r_state   <= ST_CMD;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            // io0 advances on the falling edge so it is stable across the next rise
            ST_CMD, ST_ADDR: begin
               if (w_fall) begin
                  r_io0 <= r_tx[30];
                  r_tx  <= {r_tx[29:0], 1'b0};
                  if (r_bit_cnt != 5'd0) begin
                     r_bit_cnt <= r_bit_cnt - 5'd1;
                  end else if (r_state == ST_CMD) begin
                     r_bit_cnt <= 5'(ADDR_BITS - 1);
                     r_state   <= ST_ADDR;
                  end else begin
                     r_io0     <= 1'b0;
                     r_bit_cnt <= 5'(DATA_BITS - 1);
`ifdef SPI_FLASH_FAST_READ_EN
                     r_dummy_cnt <= 3'(DUMMY_BITS - 1);
                     r_state     <= ST_DUMMY;
`else
                     r_state     <= ST_DATA;
`endif
                  end
               end
            end
`ifdef SPI_FLASH_FAST_READ_EN
            ST_DUMMY: begin
               if (w_fall) begin
                  if (r_dummy_cnt != 3'd0) r_dummy_cnt <= r_dummy_cnt - 3'd1;
                  else                     r_state     <= ST_DATA;
               end
            end
`endif
            ST_DATA: begin
               if (w_rise) r_rx <= {r_rx[30:0], flash_io1};
               if (w_fall) begin
                  if (r_bit_cnt != 5'd0) begin
                     r_bit_cnt <= r_bit_cnt - 5'd1;
                  end else begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= byte_swap(r_rx);
                     r_csb       <= 1'b1;
                     r_state     <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_gap_cnt <= 8'(CSB_GAP - 1);
               r_state   <= ST_GAP;
            end
            ST_GAP: begin
               if (r_gap_cnt != 8'd0) begin
                  r_gap_cnt <= r_gap_cnt - 8'd1;
               end else begin
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
